// File: rtl/mse_host_pkg.sv
// Shared types and helpers for the MCU strobe bus to Avalon-MM sequencer.
// Holds the FSM state encoding plus the byte-lane select and byteenable decode.
package mse_host_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        RDV  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic logic [7:0] lane_select(input logic [31:0] word, input logic [1:0] offset);
        logic [7:0] lane_s;
        case (offset)
            2'd0:    lane_s = word[7:0];
            2'd1:    lane_s = word[15:8];
            2'd2:    lane_s = word[23:16];
            2'd3:    lane_s = word[31:24];
            default: lane_s = word[7:0];
        endcase
        return lane_s;
    endfunction

    function automatic logic [3:0] be_decode(input logic [1:0] offset);
        logic [3:0] be_s;
        case (offset)
            2'd0:    be_s = 4'b0001;
            2'd1:    be_s = 4'b0010;
            2'd2:    be_s = 4'b0100;
            2'd3:    be_s = 4'b1000;
            default: be_s = 4'b0001;
        endcase
        return be_s;
    endfunction

endpackage

// File: rtl/mse_host_seq_sync.sv
// Multi-stage synchroniser for one asynchronous strobe, cleared by the block reset.
module mse_sync_bit #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] pipe_r;

    // Shift the raw strobe through the metastability chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe_r <= {STAGES{1'b0}};
        end else begin
            pipe_r <= {pipe_r[STAGES-2:0], d};
        end
    end

    assign q = pipe_r[STAGES-1];

endmodule

// File: rtl/mse_host_seq.sv
// Sequencer turning one asynchronous MCU RD/WR strobe into exactly one Avalon-MM
// access, holding the MCU in WAIT until the access completes or times out.
module mse_host_seq
    import mse_host_pkg::*;
#(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [7:0]  ERR_RDATA      = 8'hFF
) (
    input  logic        csi_MCLK_clk,
    input  logic        rsi_MRST_reset_n,
    input  logic [7:0]  coe_M1_ADDR,
    input  logic [7:0]  coe_M1_DATA_IN,
    output logic [7:0]  coe_M1_DATA_OUT,
    output logic        coe_M1_DATA_OE,
    input  logic        coe_M1_RD,
    input  logic        coe_M1_WR,
    output logic        coe_M1_WAIT,
    output logic        coe_M1_ERR,
    output logic [7:0]  avm_M1_address,
    output logic [31:0] avm_M1_writedata,
    output logic [3:0]  avm_M1_byteenable,
    output logic        avm_M1_write,
    output logic        avm_M1_read,
    output logic        avm_M1_begintransfer,
    input  logic [31:0] avm_M1_readdata,
    input  logic        avm_M1_readdatavalid,
    input  logic        avm_M1_waitrequest
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic             rst_n_s;
    logic [1:0]       rst_pipe_r;
    logic             rd_s;
    logic             wr_s;
    state_t           state_r;
    state_t           state_nx_s;
    logic             dir_rd_r;
    logic             dir_nx_s;
    logic [1:0]       offset_r;
    logic [CNT_W-1:0] cnt_r;
    logic             timeout_hit_s;
    logic             take_rdata_s;
    logic             abort_s;
    logic             start_s;
    logic             err_r;
    logic [7:0]       data_out_r;
    logic [7:0]       address_r;
    logic [31:0]      writedata_r;
    logic [3:0]       byteenable_r;
    logic             read_r;
    logic             write_r;
    logic             begintransfer_r;

    // Reset asserts asynchronously and is released on a clock edge
    always_ff @(posedge csi_MCLK_clk or negedge rsi_MRST_reset_n) begin
        if (!rsi_MRST_reset_n) begin
            rst_pipe_r <= 2'b00;
        end else begin
            rst_pipe_r <= {rst_pipe_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_pipe_r[1];

    mse_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_rd (
        .clk   (csi_MCLK_clk),
        .rst_n (rst_n_s),
        .d     (coe_M1_RD),
        .q     (rd_s)
    );

    mse_sync_bit #(.STAGES(SYNC_STAGES)) u_sync_wr (
        .clk   (csi_MCLK_clk),
        .rst_n (rst_n_s),
        .d     (coe_M1_WR),
        .q     (wr_s)
    );

    assign timeout_hit_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));
    assign start_s       = (state_r == IDLE) & (rd_s | wr_s);
    assign dir_nx_s      = (state_r == IDLE) ? rd_s : dir_rd_r;

    // Next-state decode; a completed handshake wins over a coincident timeout
    always_comb begin
        state_nx_s   = state_r;
        take_rdata_s = 1'b0;
        abort_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (rd_s & wr_s) begin
                    state_nx_s = DONE;
                end else if (rd_s | wr_s) begin
                    state_nx_s = CMD;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            CMD: begin
                if (!avm_M1_waitrequest) begin
                    if (dir_rd_r & avm_M1_readdatavalid) begin
                        take_rdata_s = 1'b1;
                        state_nx_s   = DONE;
                    end else if (dir_rd_r) begin
                        state_nx_s = RDV;
                    end else begin
                        state_nx_s = DONE;
                    end
                end else if (timeout_hit_s) begin
                    abort_s    = 1'b1;
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = CMD;
                end
            end
            RDV: begin
                if (avm_M1_readdatavalid) begin
                    take_rdata_s = 1'b1;
                    state_nx_s   = DONE;
                end else if (timeout_hit_s) begin
                    abort_s    = 1'b1;
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = RDV;
                end
            end
            DONE: begin
                if (!rd_s && !wr_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge csi_MCLK_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Avalon command outputs are registered from the next state so they align with CMD
    always_ff @(posedge csi_MCLK_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            read_r          <= 1'b0;
            write_r         <= 1'b0;
            begintransfer_r <= 1'b0;
            address_r       <= 8'h00;
            byteenable_r    <= 4'b0000;
            writedata_r     <= 32'h0000_0000;
        end else begin
            read_r          <= (state_nx_s == CMD) & dir_nx_s;
            write_r         <= (state_nx_s == CMD) & ~dir_nx_s;
            begintransfer_r <= (state_r == IDLE) & (state_nx_s == CMD);
            if (start_s) begin
                address_r    <= {coe_M1_ADDR[7:2], 2'b00};
                byteenable_r <= be_decode(coe_M1_ADDR[1:0]);
                writedata_r  <= {4{coe_M1_DATA_IN}};
            end else begin
                address_r    <= address_r;
                byteenable_r <= byteenable_r;
                writedata_r  <= writedata_r;
            end
        end
    end

    // Transaction context, timeout counter, sticky error and returned read byte
    always_ff @(posedge csi_MCLK_clk or negedge rst_n_s) begin
        if (!rst_n_s) begin
            dir_rd_r   <= 1'b0;
            offset_r   <= 2'b00;
            cnt_r      <= {CNT_W{1'b0}};
            err_r      <= 1'b0;
            data_out_r <= 8'h00;
        end else if (start_s) begin
            dir_rd_r <= rd_s;
            offset_r <= coe_M1_ADDR[1:0];
            cnt_r    <= {CNT_W{1'b0}};
            err_r    <= rd_s & wr_s;
            if (rd_s & wr_s) begin
                data_out_r <= ERR_RDATA;
            end else begin
                data_out_r <= data_out_r;
            end
        end else if ((state_r == CMD) || (state_r == RDV)) begin
            cnt_r <= cnt_r + CNT_W'(1);
            if (abort_s) begin
                err_r      <= 1'b1;
                data_out_r <= ERR_RDATA;
            end else if (take_rdata_s) begin
                data_out_r <= lane_select(avm_M1_readdata, offset_r);
            end else begin
                data_out_r <= data_out_r;
            end
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // WAIT and DATA_OE follow the raw pins so the MCU sees them without clock latency
    assign coe_M1_WAIT     = (coe_M1_RD | coe_M1_WR) & (state_r != DONE);
    assign coe_M1_DATA_OE  = coe_M1_RD & dir_rd_r & (state_r == DONE);
    assign coe_M1_DATA_OUT = data_out_r;
    assign coe_M1_ERR      = err_r;

    assign avm_M1_address       = address_r;
    assign avm_M1_writedata     = writedata_r;
    assign avm_M1_byteenable    = byteenable_r;
    assign avm_M1_read          = read_r;
    assign avm_M1_write         = write_r;
    assign avm_M1_begintransfer = begintransfer_r;

endmodule
